// File: rtl/semaforo_pkg.sv
// semaforo_pkg: color codes, FSM state codes and sequencing helpers shared by the traffic and pedestrian signal blocks
package semaforo_pkg;

    localparam logic [1:0] ROJO     = 2'b00;
    localparam logic [1:0] AMARILLO = 2'b01;
    localparam logic [1:0] VERDE    = 2'b10;

    typedef enum logic [2:0] {
        ROJO_A  = 3'd0,
        VERDE_A = 3'd1,
        AMAR_A  = 3'd2,
        ROJO_B  = 3'd3,
        VERDE_B = 3'd4,
        AMAR_B  = 3'd5
    } estado_t;

    function automatic estado_t siguiente(input estado_t e);
        return (e == AMAR_B) ? ROJO_A : estado_t'(e + 3'd1);
    endfunction

    function automatic logic [1:0] color_a(input estado_t e);
        return (e == VERDE_A) ? VERDE : (e == AMAR_A) ? AMARILLO : ROJO;
    endfunction

    function automatic logic [1:0] color_b(input estado_t e);
        return (e == VERDE_B) ? VERDE : (e == AMAR_B) ? AMARILLO : ROJO;
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// temporizador_fase: per-phase cycle counter, flags the last cycle of the selected duration
module temporizador_fase #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         ENB,
    input  logic         clr,
    input  logic [W-1:0] limite,
    output logic         fin,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // restart on phase change, count only while enabled
    always_comb cnt_d = clr ? '0 : ENB ? cnt_q + 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge clk) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign fin = ENB && (cnt_q == limite - 1'b1);
    assign cnt = cnt_q;

endmodule

// File: rtl/controlador_semaforo.sv
// controlador_semaforo: fixed-time two-way light controller; define SEMAFORO_PEATON_EN for pedestrian-shortened greens
module controlador_semaforo
    import semaforo_pkg::*;
#(
    parameter int T_ROJO      = 2,
    parameter int T_VERDE     = 20,
    parameter int T_VERDE_MIN = 5,
    parameter int T_AMARILLO  = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       ENB,
    input  logic       pideA,
    input  logic       pideB,
    output logic [1:0] SemaforoA,
    output logic [1:0] SemaforoB,
    output logic       esperaA,
    output logic       esperaB,
    output logic [2:0] fase
);

    localparam int T_MAX1 = (T_ROJO > T_VERDE) ? T_ROJO : T_VERDE;
    localparam int T_MAX  = (T_MAX1 > T_AMARILLO) ? T_MAX1 : T_AMARILLO;
    localparam int W      = $clog2(T_MAX + 1);
    localparam logic [W-1:0] VMIN = W'(T_VERDE_MIN - 1);

    estado_t      estado_q, estado_d;
    logic [1:0]   sem_a_q, sem_a_d, sem_b_q, sem_b_d;
    logic         espera_a_q, espera_a_d, espera_b_q, espera_b_d;
    logic [W-1:0] limite, cnt;
    logic         fin, corta, avanza;

    temporizador_fase #(.W(W)) u_tmr (
        .clk    (clk),
        .RST    (RST),
        .ENB    (ENB),
        .clr    (avanza),
        .limite (limite),
        .fin    (fin),
        .cnt    (cnt)
    );

    // phase duration for the current state
    always_comb limite = (estado_q == VERDE_A || estado_q == VERDE_B) ? W'(T_VERDE) :
                         (estado_q == AMAR_A  || estado_q == AMAR_B)  ? W'(T_AMARILLO) : W'(T_ROJO);

`ifdef SEMAFORO_PEATON_EN
    // latch requests in each approach's window, cut green once the minimum has elapsed
    always_comb begin
        corta      = ENB && cnt >= VMIN &&
                     ((estado_q == VERDE_A && espera_a_q) || (estado_q == VERDE_B && espera_b_q));
        espera_a_d = (avanza && estado_q == VERDE_A) ? 1'b0 :
                     espera_a_q | (ENB && pideA && (estado_q == ROJO_A || estado_q == VERDE_A));
        espera_b_d = (avanza && estado_q == VERDE_B) ? 1'b0 :
                     espera_b_q | (ENB && pideB && (estado_q == ROJO_B || estado_q == VERDE_B));
    end
`else
    // pedestrian logic absent: requests ignored, green always runs full length
    always_comb begin
        corta      = 1'b0 & (cnt >= VMIN);
        espera_a_d = 1'b0 & pideA;
        espera_b_d = 1'b0 & pideB;
    end
`endif

    // next state and registered color decode, colors follow the new state
    always_comb begin
        avanza   = fin | corta;
        estado_d = avanza ? siguiente(estado_q) : estado_q;
        sem_a_d  = color_a(estado_d);
        sem_b_d  = color_b(estado_d);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (RST) begin
            estado_q   <= ROJO_A;
            sem_a_q    <= ROJO;
            sem_b_q    <= ROJO;
            espera_a_q <= 1'b0;
            espera_b_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            sem_a_q    <= sem_a_d;
            sem_b_q    <= sem_b_d;
            espera_a_q <= espera_a_d;
            espera_b_q <= espera_b_d;
        end
    end

    assign SemaforoA = sem_a_q;
    assign SemaforoB = sem_b_q;
    assign esperaA   = espera_a_q;
    assign esperaB   = espera_b_q;
    assign fase      = estado_q;

endmodule
